seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 165 ++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 7-segment digit scanner with dead-time between slots,
// leading-zero/invalid-digit blanking and frame-synchronous display updates.
module seven_segment_scanner #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StOff, StDrive, StDead} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;

    logic                    accept;
    logic                    advance;
    logic                    wrap;
    logic                    frame_d;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   en_d;
    logic [3:0]              bcd_d;

    assign accept = load_valid && load_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        display_d    = display_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        advance      = 1'b0;
        wrap         = 1'b0;
        frame_d      = 1'b0;

        unique case (state_q)
            StOff: begin
                idx_d = '0;
                cnt_d = '0;
                if (enable) state_d = StDrive;
            end
            StDrive: begin
                if (!enable) begin
                    state_d = StOff;
                end else if (cnt_q == DRIVE_LAST) begin
                    cnt_d = '0;
                    if (DEAD_CYCLES == 0) advance = 1'b1;
                    else                  state_d = StDead;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDead: begin
                if (!enable) begin
                    state_d = StOff;
                end else if (cnt_q == DEAD_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                    state_d = StDrive;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StOff;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                wrap    = 1'b1;
                frame_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (state_q == StOff) begin
            if (accept) display_d = load_data;
        end else if (state_d == StOff) begin
            // Going dark: whatever is queued becomes visible on the next enable.
            idx_d        = '0;
            cnt_d        = '0;
            pend_valid_d = 1'b0;
            if (accept)            display_d = load_data;
            else if (pend_valid_q) display_d = pend_q;
        end else begin
            if (wrap && pend_valid_q) begin
                display_d    = pend_q;
                pend_valid_d = 1'b0;
            end
            // Data accepted on the boundary edge waits for the following frame.
            if (accept) begin
                pend_d       = load_data;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Blanking and registered outputs are derived from next-state values so
    // the visible digit always matches the state it is driven in.
    always_comb begin
        blank      = '0;
        zero_above = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (display_d[4*i +: 4] == 4'd0);
            blank[i]   = (display_d[4*i +: 4] > 4'd9) || (zero_above && (i != 0));
        end
        en_d  = '0;
        bcd_d = digit_bcd;
        if (state_d == StDrive) begin
            en_d  = (NUM_DIGITS'(1) << idx_d) & ~blank;
            bcd_d = display_d[{idx_d, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StOff;
            idx_q        <= '0;
            cnt_q        <= '0;
            display_q    <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            digit_en     <= '0;
            digit_bcd    <= '0;
            frame_done   <= 1'b0;
            load_ready   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            display_q    <= display_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            digit_en     <= en_d;
            digit_bcd    <= bcd_d;
            frame_done   <= frame_d;
            load_ready   <= !pend_valid_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=4,
// DEAD_CYCLES=1, giving a 20-cycle frame of four 5-cycle slots.
module tb_seven_segment_scanner;

    localparam int FRAME = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        blank_lz = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        load_ready;
    logic [3:0]  digit_bcd;
    logic [3:0]  digit_en;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    seven_segment_scanner #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .DEAD_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .blank_lz  (blank_lz),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .digit_bcd (digit_bcd),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // k counts cycles from the first lit cycle of a frame; slot = k/5, slot
    // phase 4 is the dark dead cycle.
    function automatic logic [3:0] exp_en(input int k, input logic [3:0] lit);
        int s;
        s = (k / 5) % 4;
        if ((k % 5) < 4 && lit[s]) return 4'b0001 << s;
        return 4'b0000;
    endfunction

    function automatic logic [3:0] exp_bcd(input int k, input logic [15:0] d);
        int s;
        s = (k / 5) % 4;
        return d[4*s +: 4];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic [15:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        enable     = 1'b1;
        tick();
    endtask

    task automatic stop();
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (digit_en !== 4'b0000 || digit_bcd !== 4'h0 || frame_done !== 1'b0
            || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: en=%b bcd=%h fd=%b rdy=%b want en=0000 bcd=0 fd=0 rdy=1",
                     digit_en, digit_bcd, frame_done, load_ready);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (digit_en !== 4'b0000 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_off: en=%b rdy=%b want en=0000 rdy=1", digit_en, load_ready);
        end
    endtask

    task automatic test_scan();
        start(16'h1234);
        for (int k = 0; k <= FRAME; k++) begin
            checks++;
            if (digit_en !== exp_en(k, 4'b1111) || digit_bcd !== exp_bcd(k, 16'h1234)
                || frame_done !== (k == FRAME) || load_ready !== 1'b1) begin
                failures++;
                $display("FAIL scan k=%0d: en=%b bcd=%h fd=%b rdy=%b want en=%b bcd=%h fd=%b rdy=1",
                         k, digit_en, digit_bcd, frame_done, load_ready,
                         exp_en(k, 4'b1111), exp_bcd(k, 16'h1234), k == FRAME);
            end
            if (k < FRAME) tick();
        end
        enable = 1'b0;
        tick();
        checks++;
        if (digit_en !== 4'b0000) begin
            failures++;
            $display("FAIL disable_dark: en=%b want 0000", digit_en);
        end
        tick();
    endtask

    task automatic test_blank_lz();
        blank_lz = 1'b1;
        start(16'h0070);
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (digit_en !== exp_en(k, 4'b0011) || digit_bcd !== exp_bcd(k, 16'h0070)) begin
                failures++;
                $display("FAIL blank_lz_on k=%0d: en=%b bcd=%h want en=%b bcd=%h",
                         k, digit_en, digit_bcd, exp_en(k, 4'b0011), exp_bcd(k, 16'h0070));
            end
            tick();
        end
        stop();
        blank_lz = 1'b0;
        start(16'h0070);
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (digit_en !== exp_en(k, 4'b1111) || digit_bcd !== exp_bcd(k, 16'h0070)) begin
                failures++;
                $display("FAIL blank_lz_off k=%0d: en=%b bcd=%h want en=%b bcd=%h",
                         k, digit_en, digit_bcd, exp_en(k, 4'b1111), exp_bcd(k, 16'h0070));
            end
            tick();
        end
        stop();
    endtask

    task automatic test_invalid_digit();
        start(16'h1A34);
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (digit_en !== exp_en(k, 4'b1011) || digit_bcd !== exp_bcd(k, 16'h1A34)) begin
                failures++;
                $display("FAIL invalid_digit k=%0d: en=%b bcd=%h want en=%b bcd=%h",
                         k, digit_en, digit_bcd, exp_en(k, 4'b1011), exp_bcd(k, 16'h1A34));
            end
            tick();
        end
        stop();
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic        rdy;
        start(16'h1234);
        for (int k = 0; k <= 2 * FRAME; k++) begin
            d   = (k < FRAME) ? 16'h1234 : 16'h5678;
            rdy = !(k >= 7 && k < FRAME);
            checks++;
            if (digit_en !== exp_en(k, 4'b1111) || digit_bcd !== exp_bcd(k, d)
                || frame_done !== (k == FRAME || k == 2 * FRAME) || load_ready !== rdy) begin
                failures++;
                $display("FAIL pending k=%0d: en=%b bcd=%h fd=%b rdy=%b want en=%b bcd=%h rdy=%b",
                         k, digit_en, digit_bcd, frame_done, load_ready,
                         exp_en(k, 4'b1111), exp_bcd(k, d), rdy);
            end
            // Slot 1: offer 5678; later offer FFFF while not ready (must be ignored).
            if (k == 6)  begin load_valid = 1'b1; load_data = 16'h5678; end
            if (k == 7)  load_valid = 1'b0;
            if (k == 10) begin load_valid = 1'b1; load_data = 16'hFFFF; end
            if (k == 11) load_valid = 1'b0;
            if (k < 2 * FRAME) tick();
        end
        stop();
    endtask

    task automatic test_off_commit();
        start(16'h1234);
        for (int k = 0; k <= 11; k++) begin
            if (k == 6) begin load_valid = 1'b1; load_data = 16'h9999; end
            if (k == 7) load_valid = 1'b0;
            if (k < 11) tick();
        end
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL off_pending_ready: rdy=%b want 0", load_ready);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (digit_en !== 4'b0000 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL off_entry: en=%b rdy=%b fd=%b want en=0000 rdy=1 fd=0",
                     digit_en, load_ready, frame_done);
        end
        tick();
        enable = 1'b1;
        tick();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (digit_en !== exp_en(k, 4'b1111) || digit_bcd !== exp_bcd(k, 16'h9999)) begin
                failures++;
                $display("FAIL off_commit k=%0d: en=%b bcd=%h want en=%b bcd=%h",
                         k, digit_en, digit_bcd, exp_en(k, 4'b1111), exp_bcd(k, 16'h9999));
            end
            tick();
        end
        stop();
    endtask

    task automatic test_async_reset();
        start(16'h4321);
        load_valid = 1'b1;
        load_data  = 16'h5678;
        tick();
        load_valid = 1'b0;
        tick();
        checks++;
        if (load_ready !== 1'b0 || digit_en !== 4'b0001) begin
            failures++;
            $display("FAIL pre_reset: rdy=%b en=%b want rdy=0 en=0001", load_ready, digit_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (digit_en !== 4'b0000 || load_ready !== 1'b1 || digit_bcd !== 4'h0
            || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: en=%b rdy=%b bcd=%h fd=%b want en=0000 rdy=1 bcd=0 fd=0",
                     digit_en, load_ready, digit_bcd, frame_done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (digit_en !== exp_en(k, 4'b1111) || digit_bcd !== 4'h0 || load_ready !== 1'b1) begin
                failures++;
                $display("FAIL post_reset k=%0d: en=%b bcd=%h rdy=%b want en=%b bcd=0 rdy=1",
                         k, digit_en, digit_bcd, load_ready, exp_en(k, 4'b1111));
            end
            tick();
        end
        stop();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_lz();
        test_invalid_digit();
        test_back_to_back();
        test_off_commit();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
